// File: rtl/tt_uart_tx_fifo_if.sv
// Byte-enqueue handshake between a producer and the UART transmitter FIFO.
interface tt_uart_tx_fifo_if;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;

  modport master (
    output wr_data,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_ready
  );
endinterface

// File: rtl/tt_uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, fed by a small circular-buffer FIFO.
// Stop-bit completion with a non-empty FIFO chains straight into the next start bit.
module tt_uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  tt_uart_tx_fifo_if.slave              wr_if,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = 16;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            bit_end;

  // Next-state, FIFO pointer and registered-output computation
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;

    full    = (count_q == DEPTH);
    empty   = (count_q == CW'(0));
    bit_end = (baud_q == BW'(0));
    // Fullness is judged before any same-cycle pop, so a write while full is lost
    push    = wr_if.wr_valid && ready_q;

    if (wr_if.wr_valid && full) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_START;
          baud_d  = BAUD_MAX;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_d  = BAUD_MAX;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d  = BAUD_MAX;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_d = BAUD_MAX;
          if (!empty) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      shift_d = mem_q[rptr_q[AW-1:0]];
      rptr_d  = rptr_q + CW'(1);
    end
    if (push) begin
      wptr_d = wptr_q + CW'(1);
    end

    count_d = wptr_d - rptr_d;
    ready_d = (count_d != DEPTH);
    busy_d  = (state_d != ST_IDLE) || (count_d != CW'(0));

    // Line level follows the state being entered so tx changes on the same edge
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: pointers alone define valid contents
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= wr_if.wr_data;
    end
  end

  assign wr_if.wr_ready = ready_q;
  assign tx             = tx_q;
  assign busy           = busy_q;
  assign fifo_count     = count_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_tt_uart_tx_fifo.sv
// Directed bench for tt_uart_tx_fifo: reset, single frame, back-to-back, overflow, mid-frame reset.
module tb_tt_uart_tx_fifo;
  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;
  logic       busy_last;
  int         total = 0;
  int         bad   = 0;

  tt_uart_tx_fifo_if bus ();

  tt_uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_if      (bus),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.wr_data  = d;
    bus.wr_valid = 1'b1;
    tick();
  endtask

  // Entered just after an edge inside the start bit; start_left samples of it remain.
  // Returns just after the edge that ends the stop bit.
  task automatic expect_frame(input logic [7:0] b, input int start_left, input bit poke,
                              input string tag);
    int         errs;
    int         n;
    logic       e;
    logic [7:0] got;
    got = 8'h00;
    for (int k = 0; k < 10; k++) begin
      n = (k == 0) ? start_left : int'(CPB);
      if (k == 0)      e = 1'b0;
      else if (k == 9) e = 1'b1;
      else             e = b[k-1];
      errs = 0;
      for (int i = 0; i < n; i++) begin
        if (tx !== e) errs++;
        if (k >= 1 && k <= 8 && i == n / 2) got[k-1] = tx;
        if (k == 9 && i == n - 1) begin
          busy_last = busy;
          if (poke) begin
            bus.wr_data  = 8'h77;
            bus.wr_valid = 1'b1;
          end
        end
        tick();
      end
      chk($sformatf("%s_bit%0d", tag, k), errs, 0);
    end
    chk($sformatf("%s_byte", tag), got, b);
  endtask

  initial begin
    int lows;
    int highs;
    bus.wr_data  = 8'h00;
    bus.wr_valid = 1'b0;
    rst          = 1'b1;

    // Reset
    repeat (3) tick();
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.wr_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();
    lows = 0;
    repeat (50) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    chk("idle_tx_lows", lows, 0);
    chk("idle_busy", busy, 0);

    // Single byte 0xA5
    push_byte(8'hA5);
    bus.wr_valid = 1'b0;
    chk("s_cnt_after_write", fifo_count, 1);
    chk("s_tx_before_pop", tx, 1);
    chk("s_busy_after_write", busy, 1);
    tick();
    chk("s_cnt_after_pop", fifo_count, 0);
    expect_frame(8'hA5, 16, 1'b0, "s");
    chk("s_busy_last_stop", busy_last, 1);
    chk("s_busy_at_161", busy, 0);
    repeat (5) tick();

    // Back-to-back 0x00, 0xFF, 0x55
    push_byte(8'h00);
    chk("b_cnt1", fifo_count, 1);
    push_byte(8'hFF);
    chk("b_cnt2", fifo_count, 1);
    push_byte(8'h55);
    bus.wr_valid = 1'b0;
    chk("b_peak", fifo_count, 2);
    expect_frame(8'h00, 15, 1'b0, "b0");
    expect_frame(8'hFF, 16, 1'b0, "b1");
    expect_frame(8'h55, 16, 1'b0, "b2");
    chk("b_busy_end", busy, 0);
    chk("b_cnt_end", fifo_count, 0);
    repeat (5) tick();

    // Overflow: 0x01 shifts, 0x02..0x05 fill, 0x06 dropped
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_byte(8'h04);
    push_byte(8'h05);
    chk("o_full_cnt", fifo_count, 4);
    chk("o_full_ready", bus.wr_ready, 0);
    chk("o_full_ovf", overflow, 0);
    push_byte(8'h06);
    bus.wr_valid = 1'b0;
    chk("o_drop_cnt", fifo_count, 4);
    chk("o_drop_ovf", overflow, 1);
    // 0x77 offered at the STOP-end edge while full: dropped, the pop still happens
    expect_frame(8'h01, 12, 1'b1, "o1");
    bus.wr_valid = 1'b0;
    chk("o_sim_cnt", fifo_count, 3);
    chk("o_sim_ovf", overflow, 1);
    chk("o_sim_ready", bus.wr_ready, 1);
    expect_frame(8'h02, 16, 1'b0, "o2");
    expect_frame(8'h03, 16, 1'b0, "o3");
    expect_frame(8'h04, 16, 1'b0, "o4");
    expect_frame(8'h05, 16, 1'b0, "o5");
    chk("o_busy_end", busy, 0);
    chk("o_cnt_end", fifo_count, 0);
    chk("o_ovf_sticky", overflow, 1);
    lows = 0;
    repeat (20) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    chk("o_no_extra_frame", lows, 0);

    // Mid-frame reset during bit 3 of 0xC3 with two bytes queued
    push_byte(8'hC3);
    push_byte(8'h11);
    push_byte(8'h22);
    bus.wr_valid = 1'b0;
    chk("r_cnt", fifo_count, 2);
    repeat (39) tick();
    chk("r_bit1", tx, 1);
    repeat (32) tick();
    chk("r_bit3", tx, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("r_tx_async", tx, 1);
    chk("r_cnt_async", fifo_count, 0);
    chk("r_busy_async", busy, 0);
    chk("r_ready_async", bus.wr_ready, 1);
    chk("r_ovf_cleared", overflow, 0);
    tick();
    tick();
    rst = 1'b0;
    lows  = 0;
    highs = 0;
    repeat (400) begin
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) highs++;
      tick();
    end
    chk("r_post_tx_lows", lows, 0);
    chk("r_post_busy_cycles", highs, 0);
    chk("r_post_cnt", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
